// File: rtl/jk_excitation_driver.sv
// -----------------------------------------------------------------------------
// jk_excitation_driver
//
// Purpose:
//   Drive side for a JK (or master-slave JK) flip-flop. A frame of WIDTH target
//   Q bits is accepted over a valid/ready handshake. The bits are applied
//   LSB first: for each bit the block drives registered j/k values taken from
//   the JK excitation table. It then checks the flip-flop's q feedback against
//   the target bit, two cycles later.
//
//   Timing relative to the accept edge E0, for bit i:
//     E0+1+i  j/k for bit i registered on the outputs
//     E0+2+i  flip-flop samples j/k and updates
//     E0+3+i  q_fb compared against bit i (mismatch / err_cnt registered)
//   Frame period is WIDTH+4 cycles; done pulses at E0+WIDTH+3.
//
// Parameters:
//   WIDTH    target bits per frame
//   DC_MODE  value driven on excitation don't-care terms
//   ERR_W    width of the saturating mismatch counter
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   synchronous reset, active-low
//   in_valid  in   in_data holds a frame
//   in_ready  out  block can accept a frame (idle)
//   in_data   in   target Q sequence, bit 0 applied first
//   q_fb      in   Q output of the driven flip-flop
//   clr_err   in   synchronous clear of err_cnt (wins over an increment)
//   j, k      out  registered J/K drive
//   busy      out  frame in progress
//   done      out  one-cycle pulse, frame complete
//   mismatch  out  one-cycle pulse, q_fb differed from the expected bit
//   err_cnt   out  cumulative mismatches, saturating at all-ones
// -----------------------------------------------------------------------------
module jk_excitation_driver #(
  parameter int WIDTH   = 8,
  parameter bit DC_MODE = 1'b0,
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             q_fb,
  input  logic             clr_err,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // JK excitation table, returns {j, k} to move q_cur to q_tgt.
  function automatic logic [1:0] jk_excite(input logic q_cur, input logic q_tgt);
    logic [1:0] jk;
    if (q_cur == 1'b0) begin
      jk = {q_tgt, DC_MODE};
    end else begin
      jk = {DC_MODE, ~q_tgt};
    end
    return jk;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             q_model_q, q_model_d;
  logic             j_q, j_d;
  logic             k_q, k_d;
  // Two-stage (valid, expected) delay line aligning targets with q_fb.
  logic             v1_q, v1_d;
  logic             exp1_q, exp1_d;
  logic             v2_q, v2_d;
  logic             exp2_q, exp2_d;
  logic             mismatch_q, mismatch_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             in_ready_q, in_ready_d;
  logic             tgt_bit;

  // Next-state, drive and check computation.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    idx_d     = idx_q;
    q_model_d = q_model_q;
    j_d       = 1'b0;
    k_d       = 1'b0;
    done_d    = 1'b0;
    v1_d      = 1'b0;
    exp1_d    = exp1_q;
    tgt_bit   = data_q[idx_q];

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d    = in_data;
          q_model_d = q_fb;
          idx_d     = {IDX_W{1'b0}};
          state_d   = ST_DRIVE;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        {j_d, k_d} = jk_excite(q_model_q, tgt_bit);
        // q_model tracks the target, never the feedback: a faulty cell
        // must keep producing mismatches rather than being re-synced.
        q_model_d  = tgt_bit;
        v1_d       = 1'b1;
        exp1_d     = tgt_bit;
        if (idx_q == LAST_IDX) begin
          state_d = ST_DRAIN;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      ST_DRAIN: begin
        // Leave once the last target has moved out of stage 1; its compare
        // lands on the same edge that enters DONE.
        if (!v1_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    v2_d       = v1_q;
    exp2_d     = exp1_q;
    mismatch_d = v2_q && (q_fb != exp2_q);

    if (clr_err) begin
      err_cnt_d = {ERR_W{1'b0}};
    end else if (mismatch_d && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end else begin
      err_cnt_d = err_cnt_q;
    end

    busy_d     = (state_d != ST_IDLE);
    in_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      data_q     <= {WIDTH{1'b0}};
      idx_q      <= {IDX_W{1'b0}};
      q_model_q  <= 1'b0;
      j_q        <= 1'b0;
      k_q        <= 1'b0;
      v1_q       <= 1'b0;
      exp1_q     <= 1'b0;
      v2_q       <= 1'b0;
      exp2_q     <= 1'b0;
      mismatch_q <= 1'b0;
      err_cnt_q  <= {ERR_W{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      q_model_q  <= q_model_d;
      j_q        <= j_d;
      k_q        <= k_d;
      v1_q       <= v1_d;
      exp1_q     <= exp1_d;
      v2_q       <= v2_d;
      exp2_q     <= exp2_d;
      mismatch_q <= mismatch_d;
      err_cnt_q  <= err_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;
  assign j        = j_q;
  assign k        = k_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign mismatch = mismatch_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// -----------------------------------------------------------------------------
// tb_jk_excitation_driver
//
// Two driver instances share stimulus: dut0 (DC_MODE=0, ERR_W=8) and
// dut1 (DC_MODE=1, ERR_W=3). Each drives its own behavioural JK flip-flop,
// which can be forced stuck at 0. Expected per-cycle outputs are pushed to a
// scoreboard queue, stamped with the cycle in which they must be seen, when a
// frame is launched. A monitor pops and compares them on falling edges.
// -----------------------------------------------------------------------------
module tb_jk_excitation_driver;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n    = 1'b0;
  logic         in_valid = 1'b0;
  logic         clr_err  = 1'b0;
  logic [W-1:0] in_data  = '0;
  logic         stuck    = 1'b0;
  logic         ffq0     = 1'b0;
  logic         ffq1     = 1'b0;

  logic       in_ready0, j0, k0, busy0, done0, mis0;
  logic [7:0] err0;
  logic       in_ready1, j1, k1, busy1, done1, mis1;
  logic [2:0] err1;

  jk_excitation_driver #(.WIDTH(W), .DC_MODE(1'b0), .ERR_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .q_fb(ffq0), .clr_err(clr_err), .j(j0), .k(k0),
    .busy(busy0), .done(done0), .mismatch(mis0), .err_cnt(err0)
  );

  jk_excitation_driver #(.WIDTH(W), .DC_MODE(1'b1), .ERR_W(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .q_fb(ffq1), .clr_err(clr_err), .j(j1), .k(k1),
    .busy(busy1), .done(done1), .mismatch(mis1), .err_cnt(err1)
  );

  // Behavioural JK flip-flops on the same edge, optionally stuck at 0.
  always @(posedge clk) begin
    if (stuck) begin
      ffq0 <= 1'b0;
      ffq1 <= 1'b0;
    end else begin
      case ({j0, k0})
        2'b01:   ffq0 <= 1'b0;
        2'b10:   ffq0 <= 1'b1;
        2'b11:   ffq0 <= ~ffq0;
        default: ffq0 <= ffq0;
      endcase
      case ({j1, k1})
        2'b01:   ffq1 <= 1'b0;
        2'b10:   ffq1 <= 1'b1;
        2'b11:   ffq1 <= ~ffq1;
        default: ffq1 <= ffq1;
      endcase
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    int          cyc;
    int          sel;
    logic [15:0] exp;
  } sb_t;

  sb_t sb[$];
  int  exp_err0 = 0;
  int  exp_err1 = 0;

  function automatic string sel_name(input int sel);
    case (sel)
      0:  return "jk0";
      1:  return "jk1";
      2:  return "mismatch0";
      3:  return "mismatch1";
      4:  return "err_cnt0";
      5:  return "err_cnt1";
      6:  return "busy0";
      7:  return "in_ready0";
      8:  return "done0";
      9:  return "busy1";
      10: return "in_ready1";
      default: return "done1";
    endcase
  endfunction

  function automatic logic [15:0] obs_val(input int sel);
    case (sel)
      0:  return {14'd0, j0, k0};
      1:  return {14'd0, j1, k1};
      2:  return {15'd0, mis0};
      3:  return {15'd0, mis1};
      4:  return {8'd0, err0};
      5:  return {13'd0, err1};
      6:  return {15'd0, busy0};
      7:  return {15'd0, in_ready0};
      8:  return {15'd0, done0};
      9:  return {15'd0, busy1};
      10: return {15'd0, in_ready1};
      default: return {15'd0, done1};
    endcase
  endfunction

  // Excitation table: {j, k} needed to go from q to t, dc on don't-cares.
  function automatic logic [15:0] exp_jk(input logic q, input logic t, input logic dc);
    case ({q, t})
      2'b00:   return {14'd0, 1'b0, dc};
      2'b01:   return {14'd0, 1'b1, dc};
      2'b10:   return {14'd0, dc, 1'b1};
      default: return {14'd0, dc, 1'b0};
    endcase
  endfunction

  task automatic push(input int c, input int sel, input logic [15:0] v);
    sb_t e;
    e.cyc = c;
    e.sel = sel;
    e.exp = v;
    sb.push_back(e);
  endtask

  // Scoreboard consumer: compare every entry due in the current cycle.
  always @(negedge clk) begin
    sb_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      check_val(sel_name(e.sel), obs_val(e.sel), e.exp);
    end
  end

  // Launch one frame. Call on a falling edge; returns on the falling edge
  // after done (where the next frame may be launched back-to-back).
  // clr_off: edge offset from the accept edge at which clr_err is sampled.
  task automatic run_frame(input logic [W-1:0] d, input int clr_off, input bit keep_valid);
    int   e0;
    int   waited;
    logic q0m, q1m, t;
    logic mis_exp;
    logic [15:0] b;
    waited = 0;
    while (!in_ready0 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready0) begin
      check_val("ready_wait", {15'd0, in_ready0}, 16'd1);
      return;
    end
    in_valid = 1'b1;
    in_data  = d;
    e0  = cyc + 1;
    q0m = ffq0;
    q1m = ffq1;
    for (int n = 0; n <= W + 3; n++) begin
      if (n >= 1 && n <= W) begin
        t = d[n-1];
        push(e0 + n, 0, exp_jk(q0m, t, 1'b0));
        push(e0 + n, 1, exp_jk(q1m, t, 1'b1));
        q0m = t;
        q1m = t;
      end else begin
        push(e0 + n, 0, 16'd0);
        push(e0 + n, 1, 16'd0);
      end
      mis_exp = (n >= 3 && n <= W + 2) ? (stuck & d[n-3]) : 1'b0;
      push(e0 + n, 2, {15'd0, mis_exp});
      push(e0 + n, 3, {15'd0, mis_exp});
      if (n == clr_off) begin
        exp_err0 = 0;
        exp_err1 = 0;
      end else if (mis_exp) begin
        if (exp_err0 < 255) exp_err0++;
        if (exp_err1 < 7)   exp_err1++;
      end
      push(e0 + n, 4, 16'(exp_err0));
      push(e0 + n, 5, 16'(exp_err1));
      b = (n <= W + 2) ? 16'd1 : 16'd0;
      push(e0 + n, 6, b);
      push(e0 + n, 9, b);
      push(e0 + n, 7, 16'd1 - b);
      push(e0 + n, 10, 16'd1 - b);
      push(e0 + n, 8, (n == W + 3) ? 16'd1 : 16'd0);
      push(e0 + n, 11, (n == W + 3) ? 16'd1 : 16'd0);
    end
    for (int n = 0; n <= W + 3; n++) begin
      @(negedge clk);
      if (n == 0) begin
        if (keep_valid) in_data = W'($urandom);
        else            in_valid = 1'b0;
      end
      clr_err = (n == clr_off - 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_jk0",      {14'd0, j0, k0}, 16'd0);
    check_val("rst_busy0",    {15'd0, busy0},  16'd0);
    check_val("rst_done0",    {15'd0, done0},  16'd0);
    check_val("rst_mis0",     {15'd0, mis0},   16'd0);
    check_val("rst_err0",     {8'd0, err0},    16'd0);
    check_val("rst_ready0",   {15'd0, in_ready0}, 16'd1);
    check_val("rst_ready1",   {15'd0, in_ready1}, 16'd1);
    check_val("rst_err1",     {13'd0, err1},   16'd0);

    // Ideal flip-flop frames, including the 8'hAC reference frame.
    run_frame(8'hAC, -1, 1'b0);
    run_frame(8'h5A, -1, 1'b0);
    for (int i = 0; i < 3; i++) run_frame(W'($urandom), -1, 1'b0);

    // Back-to-back with in_valid held high; garbage on in_data while busy.
    run_frame(8'h96, -1, 1'b1);
    run_frame(8'h0F, -1, 1'b1);
    run_frame(8'hF1, -1, 1'b0);
    repeat (3) @(negedge clk);
    check_val("idle_busy0", {15'd0, busy0}, 16'd0);

    // Stuck-at-0 flip-flop: mismatches, saturation, clear-wins.
    stuck = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(8'hFF, -1, 1'b0);
    run_frame(8'hFF, -1, 1'b0);
    run_frame(8'hFF, 5, 1'b0);
    run_frame(8'h3C, -1, 1'b0);

    // Reset mid-frame at E0+4.
    in_valid = 1'b1;
    in_data  = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    check_val("mid_busy0", {15'd0, busy0}, 16'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_val("mrst_jk0",    {14'd0, j0, k0},   16'd0);
    check_val("mrst_busy0",  {15'd0, busy0},    16'd0);
    check_val("mrst_ready0", {15'd0, in_ready0}, 16'd1);
    check_val("mrst_err0",   {8'd0, err0},      16'd0);
    check_val("mrst_err1",   {13'd0, err1},     16'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_val("post_rst_done0", {15'd0, done0}, 16'd0);
      check_val("post_rst_mis0",  {15'd0, mis0},  16'd0);
      check_val("post_rst_busy0", {15'd0, busy0}, 16'd0);
    end
    exp_err0 = 0;
    exp_err1 = 0;
    stuck = 1'b0;
    repeat (2) @(negedge clk);
    run_frame(8'hAC, -1, 1'b0);

    repeat (4) @(negedge clk);
    check_val("sb_left", 16'(sb.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
